// File: rtl/mem_stage.sv
// mem_stage: MIPS M stage; issues data-memory loads/stores over req/ack, formats data, registers M/W outputs
// Optional feature macro: MEM_MISALIGN_TRAP_EN (adds output misalign; misaligned LH/LHU/SH/LW/SW become bubbles)
// Ports:
//   clock, reset_n                     clock (rising edge), asynchronous active-low reset
//   valid_in, flush                    X/M valid and kill of the incoming instruction
//   o_in, b_in, insn_in                ALU result / effective address, store data, instruction word
//   br_in..rwd_in, aluop_in            control bundle from X
//   stall_out                          high while a data-memory access is outstanding
//   dm_req/we/addr/be/wdata, dm_ack/rdata   data-memory port
//   o, d, insn, br..rwd, aluop, valid_out   registered M/W outputs to writeback
module mem_stage #(
   parameter int ADDR_W = 32,
   parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              valid_in,
   input  logic              flush,
   input  logic [31:0]       o_in,
   input  logic [31:0]       b_in,
   input  logic [31:0]       insn_in,
   input  logic              br_in,
   input  logic              jp_in,
   input  logic              aluinb_in,
   input  logic              dmwe_in,
   input  logic              rwe_in,
   input  logic              rdst_in,
   input  logic              rwd_in,
   input  logic [5:0]        aluop_in,
   output logic              stall_out,
   output logic              dm_req,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [3:0]        dm_be,
   output logic [31:0]       dm_wdata,
   input  logic              dm_ack,
   input  logic [31:0]       dm_rdata,
   output logic [31:0]       o,
   output logic [31:0]       d,
   output logic [31:0]       insn,
   output logic              br,
   output logic              jp,
   output logic              aluinb,
   output logic              dmwe,
   output logic              rwe,
   output logic              rdst,
   output logic              rwd,
   output logic [5:0]        aluop,
   output logic              valid_out
`ifdef MEM_MISALIGN_TRAP_EN
   ,output logic             misalign
`endif
);
   typedef enum logic {IDLE, ACC} state_t;
   state_t st, nxt;
   logic [31:0] h_o, h_b, h_insn, ld;
   logic [12:0] h_ctl, ctl, ctl_in;
   logic [5:0] op;
   logic [7:0] lb;
   logic [15:0] lh;
   logic acc, mem_in, mis_in, sz_b, sz_h;
   assign acc = valid_in & ~flush;
   assign mem_in = dmwe_in | rwd_in;
   assign ctl_in = {br_in, jp_in, aluinb_in, dmwe_in, rwe_in, rdst_in, rwd_in, aluop_in};
`ifdef MEM_MISALIGN_TRAP_EN
   logic [5:0] op_in;
   assign op_in = insn_in[31:26];
   assign mis_in = mem_in & ((((op_in == 6'b100001) || (op_in == 6'b100101) || (op_in == 6'b101001)) & o_in[0]) |
                             (((op_in == 6'b100011) || (op_in == 6'b101011)) & (|o_in[1:0])));
`else
   assign mis_in = 1'b0;
`endif
   // size decode and formatting run off the hold registers so the port is stable until ack
   assign op = h_insn[31:26];
   assign sz_b = (op == 6'b100000) || (op == 6'b100100) || (op == 6'b101000);
   assign sz_h = (op == 6'b100001) || (op == 6'b100101) || (op == 6'b101001);
   assign stall_out = (st == ACC);
   assign dm_req = stall_out;
   assign dm_we = h_ctl[9];
   assign dm_addr = {h_o[ADDR_W-1:2], 2'b00};
   assign dm_be = !dm_we ? 4'b1111 : sz_b ? 4'b0001 << h_o[1:0] : sz_h ? (h_o[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign dm_wdata = !dm_we ? 32'h0 : sz_b ? {4{h_b[7:0]}} : sz_h ? {2{h_b[15:0]}} : h_b;
   assign lb = dm_rdata[{h_o[1:0], 3'b000} +: 8];
   assign lh = h_o[1] ? dm_rdata[31:16] : dm_rdata[15:0];
   // opcode bit 2 distinguishes LBU/LHU from LB/LH
   assign ld = dm_we ? 32'h0 : sz_b ? {{24{~op[2] & lb[7]}}, lb} : sz_h ? {{16{~op[2] & lh[15]}}, lh} : dm_rdata;
   assign {br, jp, aluinb, dmwe, rwe, rdst, rwd, aluop} = ctl;
   always_comb begin
      nxt = st;
      if (st == IDLE) nxt = (acc && mem_in && !mis_in) ? ACC : IDLE;
      else if (dm_ack) nxt = IDLE;
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) st <= IDLE;
      else st <= nxt;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         h_o <= '0;
         h_b <= '0;
         h_insn <= NOP_INSN;
         h_ctl <= '0;
         o <= '0;
         d <= '0;
         insn <= NOP_INSN;
         ctl <= '0;
         valid_out <= 1'b0;
      end else if (st == IDLE) begin
         h_o <= o_in;
         h_b <= b_in;
         h_insn <= insn_in;
         h_ctl <= ctl_in;
         o <= (acc && !mem_in) ? o_in : 32'h0;
         d <= '0;
         insn <= (acc && !mem_in) ? insn_in : NOP_INSN;
         ctl <= (acc && !mem_in) ? ctl_in : 13'h0;
         valid_out <= acc && !mem_in;
      end else if (dm_ack) begin
         o <= h_o;
         d <= ld;
         insn <= h_insn;
         ctl <= h_ctl;
         valid_out <= 1'b1;
      end
   end
`ifdef MEM_MISALIGN_TRAP_EN
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) misalign <= 1'b0;
      else misalign <= (st == IDLE) && acc && mis_in;
`endif
endmodule
